fust_s_issue: RTL and testbench
===============================

Name: fust_s_issue

Overview:
Issue-side consumer of the scalar functional-unit status table (FUST). Holds one row per scalar FU, written by dispatch, with operand-wait tags t1/t2. It clears tags when producers write back, picks one ready FU per cycle with a round-robin selector, and sends the selected row to that FU. Its busy vector is the `busy` feedback that dispatch consumes, so it is the issue end of the dispatch-to-issue FUST protocol.

Parameters:
NUM_FU, 3, number of scalar FUs / FUST rows (index 0..2)
TAG_W, 2, tag width; 0 = operand ready, k = wait on FU k-1
ROW_W, 32, opaque row payload width (fust_s_row_t bits)

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
en  input  1  dispatch write strobe
fu  input  2  target row/FU index (0..2; 3 illegal)
fust_row  input  ROW_W  row payload from dispatch
t1  input  TAG_W  rs1 wait tag for the written row
t2  input  TAG_W  rs2 wait tag for the written row
spec  input  1  row is dispatched under an unresolved branch
wb_valid  input  1  FU writeback this cycle
wb_tag  input  TAG_W  tag of the writing-back FU (1..3)
fu_ready  input  NUM_FU  FU i can accept an issue this cycle
flush  input  1  squash speculative rows
resolved  input  1  branch resolved correct; clear spec bits
busy  output  NUM_FU  row i occupied (registered)
issue_valid  output  1  issue this cycle
issue_fu  output  2  selected FU index
issue_row  output  ROW_W  payload of the selected row
dispatch_err  output  1  one-cycle pulse: dispatch dropped

Behaviour:
- Reset (nRST low, async): busy=0, all tags=0, spec bits=0, rr_ptr=0, dispatch_err=0. issue_valid=0 because busy is 0.
- Per-row state: busy, row, t1, t2, spec.
- Readiness: ready[i] = busy[i] & t1[i]==0 & t2[i]==0 & fu_ready[i].
- Selection is combinational from the registered state. Search starts at rr_ptr and goes upward modulo 3; the first ready row wins.
- issue_valid = any ready & !flush. issue_fu and issue_row follow the winner.
- When no row wins, issue_fu=0 and issue_row=0.
- On an issue edge: busy[winner] is cleared and rr_ptr = (winner+1) mod 3. rr_ptr holds when there is no issue.
- Wakeup: when wb_valid, every stored t1/t2 equal to wb_tag is set to 0 at the edge.
- wb_tag=0 is ignored.
- Dispatch write is accepted when en & fu<3 & (!busy[fu] | row fu issues this cycle) & !flush.
- On accept: busy=1, row, spec are stored. t1/t2 are stored with a same-cycle wakeup bypass: an incoming tag equal to wb_tag (with wb_valid) is stored as 0.
- A new row is first eligible for issue the cycle after the write (latency 1). Dispatch-to-issue minimum is 1 cycle with both tags 0.
- Dropped dispatch: when en is high but the accept condition fails, dispatch_err=1 for the next cycle and no state changes. The only exception is en during flush, which is dropped silently with no err.
- flush edge: every row with spec=1 gets busy=0 and tags cleared. Non-spec rows keep their state.
- During a flush cycle, issue_valid=0, nothing issues, and rr_ptr holds.
- resolved edge: all spec bits are cleared.
- flush & resolved in the same cycle: flush wins and resolved is ignored.
- Wakeup in a flush cycle still applies to surviving rows.
- No row waits on itself: a tag of fu+1 is legal but is only woken by a later writeback.
- fu_ready deassertion only blocks issue; the row stays busy.

Test Plan:
- Reset check: hold nRST low mid-operation with rows busy → busy=000, issue_valid=0 immediately (async). After release, rr_ptr=0.
- Single dispatch: en, fu=1, t1=t2=0, fu_ready=111 → next cycle issue_valid=1, issue_fu=1, issue_row=payload. The cycle after that, busy=000.
- Wakeup and bypass:
  - Row 0 dispatched with t1=2 while wb_valid, wb_tag=2 in the same cycle → issues the next cycle.
  - Row 2 with t2=1 and no writeback → waits until wb_tag=1, then issues one cycle later.
- Round-robin: rows 0,1,2 all ready with fu_ready held 111 → issue order 0,1,2. Re-fill all three with rr_ptr=1 → order 1,2,0.
- Flush:
  - Rows 0 (spec=1) and 1 (spec=0) busy and ready; flush=1 with resolved=1 → issue_valid=0 that cycle, then busy=010.
  - A separate resolved-only pulse clears spec, so a following flush leaves the rows intact.
- Dispatch error: en, fu=0 while busy[0]=1 and row 0 is not issuing → dispatch_err=1 for one cycle and row 0 is unchanged. en with fu=3 → dispatch_err=1.

Source files
------------

// File: rtl/fust_s_issue.sv
// fust_s_issue: issue end of the scalar FUST; clears wait tags on writeback, picks one ready
// row per cycle round-robin, and feeds the registered busy vector back to dispatch.
module fust_s_issue #(
  parameter int NUM_FU = 3,
  parameter int TAG_W  = 2,
  parameter int ROW_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic [1:0]        fu,
  input  logic [ROW_W-1:0]  fust_row,
  input  logic [TAG_W-1:0]  t1,
  input  logic [TAG_W-1:0]  t2,
  input  logic              spec,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [NUM_FU-1:0] fu_ready,
  input  logic              flush,
  input  logic              resolved,
  output logic [NUM_FU-1:0] busy,
  output logic              issue_valid,
  output logic [1:0]        issue_fu,
  output logic [ROW_W-1:0]  issue_row,
  output logic              dispatch_err
);
  logic [ROW_W-1:0]  rows  [NUM_FU];
  logic [TAG_W-1:0]  t1_q  [NUM_FU];
  logic [TAG_W-1:0]  t2_q  [NUM_FU];
  logic [NUM_FU-1:0] spec_q, ready;
  logic [1:0]        rr_ptr, win;
  logic [3:0]        busy_pad;
  logic              hit, accept;

  function automatic logic [TAG_W-1:0] wake(input logic [TAG_W-1:0] t, input logic v,
                                            input logic [TAG_W-1:0] w);
    return (v && w != '0 && t == w) ? '0 : t;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_FU; i++)
      ready[i] = busy[i] && t1_q[i] == '0 && t2_q[i] == '0 && fu_ready[i];
  end

  // Walk downward so the last hit, i.e. the closest to rr_ptr, wins.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int k = NUM_FU - 1; k >= 0; k--)
      if (ready[(int'(rr_ptr) + k) % NUM_FU]) begin
        hit = 1'b1;
        win = 2'((int'(rr_ptr) + k) % NUM_FU);
      end
  end

  assign issue_valid = hit && !flush;
  assign issue_fu    = issue_valid ? win : '0;
  assign issue_row   = issue_valid ? rows[win] : '0;
  assign busy_pad    = 4'(busy);
  assign accept      = en && fu != 2'd3 && (!busy_pad[fu] || (issue_valid && win == fu)) && !flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy         <= '0;
      spec_q       <= '0;
      rr_ptr       <= '0;
      dispatch_err <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
        rows[i] <= '0;
        t1_q[i] <= '0;
        t2_q[i] <= '0;
      end
    end else begin
      dispatch_err <= en && !accept && !flush;
      if (issue_valid) rr_ptr <= (win == 2'(NUM_FU - 1)) ? '0 : win + 2'd1;
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept && fu == 2'(i)) begin
          busy[i]   <= 1'b1;
          rows[i]   <= fust_row;
          spec_q[i] <= spec;
          t1_q[i]   <= wake(t1, wb_valid, wb_tag);
          t2_q[i]   <= wake(t2, wb_valid, wb_tag);
        end else if (flush && spec_q[i]) begin
          busy[i]   <= 1'b0;
          spec_q[i] <= 1'b0;
          t1_q[i]   <= '0;
          t2_q[i]   <= '0;
        end else begin
          if (issue_valid && win == 2'(i)) busy[i] <= 1'b0;
          if (resolved && !flush) spec_q[i] <= 1'b0;
          t1_q[i] <= wake(t1_q[i], wb_valid, wb_tag);
          t2_q[i] <= wake(t2_q[i], wb_valid, wb_tag);
        end
      end
    end
  end
endmodule

// File: tb/tb_fust_s_issue.sv
// tb_fust_s_issue: directed scenarios plus randomized traffic against a sequential model of the table.
module tb_fust_s_issue;
  logic        CLK = 0, nRST = 0, en, spec, wb_valid, flush, resolved;
  logic [1:0]  fu, t1, t2, wb_tag, issue_fu;
  logic [31:0] fust_row, issue_row;
  logic [2:0]  fu_ready, busy;
  logic        issue_valid, dispatch_err;
  int          tests = 0, fails = 0;

  fust_s_issue dut (
    .CLK(CLK), .nRST(nRST), .en(en), .fu(fu), .fust_row(fust_row), .t1(t1), .t2(t2),
    .spec(spec), .wb_valid(wb_valid), .wb_tag(wb_tag), .fu_ready(fu_ready), .flush(flush),
    .resolved(resolved), .busy(busy), .issue_valid(issue_valid), .issue_fu(issue_fu),
    .issue_row(issue_row), .dispatch_err(dispatch_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic [2:0] rdy);
    en = 0; fu = 0; fust_row = 0; t1 = 0; t2 = 0; spec = 0;
    wb_valid = 0; wb_tag = 0; flush = 0; resolved = 0; fu_ready = rdy;
  endtask

  task automatic disp(input logic [1:0] f, input logic [31:0] r, input logic [1:0] a,
                      input logic [1:0] b, input logic s, input logic [2:0] rdy);
    idle(rdy);
    en = 1; fu = f; fust_row = r; t1 = a; t2 = b; spec = s;
  endtask

  task automatic test_reset();
    idle(3'b111);
    #2;
    tests++; if (busy !== 3'b000) begin fails++; $display("FAIL reset_busy got %b exp 000", busy); end
    tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", issue_valid); end
    tests++; if (dispatch_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", dispatch_err); end
    tick(); tick();
    nRST = 1;
    disp(1, 32'h11, 0, 0, 0, 3'b111); tick();
    idle(3'b111); tick();
    disp(1, 32'h12, 0, 0, 0, 3'b000); tick();
    disp(2, 32'h13, 0, 0, 0, 3'b000); tick();
    idle(3'b111);
    #2 nRST = 0;
    #1;
    tests++; if (busy !== 3'b000) begin fails++; $display("FAIL async_reset_busy got %b exp 000", busy); end
    tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL async_reset_valid got %b exp 0", issue_valid); end
    tick();
    nRST = 1;
    disp(2, 32'h21, 0, 0, 0, 3'b000); tick();
    disp(1, 32'h22, 0, 0, 0, 3'b000); tick();
    idle(3'b111); #1;
    tests++; if (issue_fu !== 2'd1 || issue_valid !== 1'b1) begin fails++; $display("FAIL reset_ptr got v=%b fu=%0d exp v=1 fu=1", issue_valid, issue_fu); end
    tick(); tick();
  endtask

  task automatic test_single();
    disp(1, 32'hA5A5_0001, 0, 0, 0, 3'b111); #1;
    tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL single_latency got %b exp 0", issue_valid); end
    tick(); idle(3'b111); #1;
    tests++; if (issue_valid !== 1'b1 || issue_fu !== 2'd1) begin fails++; $display("FAIL single_issue got v=%b fu=%0d exp v=1 fu=1", issue_valid, issue_fu); end
    tests++; if (issue_row !== 32'hA5A5_0001) begin fails++; $display("FAIL single_row got %h exp a5a50001", issue_row); end
    tick();
    tests++; if (busy !== 3'b000 || issue_valid !== 1'b0) begin fails++; $display("FAIL single_drain got busy=%b v=%b exp 000 0", busy, issue_valid); end
  endtask

  task automatic test_wakeup();
    disp(0, 32'hB0, 2, 0, 0, 3'b111); wb_valid = 1; wb_tag = 2; tick();
    idle(3'b111); #1;
    tests++; if (issue_valid !== 1'b1 || issue_fu !== 2'd0 || issue_row !== 32'hB0) begin fails++; $display("FAIL bypass got v=%b fu=%0d row=%h exp 1 0 b0", issue_valid, issue_fu, issue_row); end
    tick();
    disp(2, 32'hC2, 0, 1, 0, 3'b111); tick();
    idle(3'b111); tick();
    tests++; if (issue_valid !== 1'b0 || busy !== 3'b100) begin fails++; $display("FAIL wait got v=%b busy=%b exp 0 100", issue_valid, busy); end
    wb_valid = 1; wb_tag = 1; #1;
    tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL wake_same_cycle got %b exp 0", issue_valid); end
    tick(); idle(3'b111); #1;
    tests++; if (issue_valid !== 1'b1 || issue_fu !== 2'd2 || issue_row !== 32'hC2) begin fails++; $display("FAIL wake_issue got v=%b fu=%0d row=%h exp 1 2 c2", issue_valid, issue_fu, issue_row); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] ord [6];
    ord = '{0, 1, 2, 1, 2, 0};
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        disp(0, 32'hD0, 0, 0, 0, 3'b111); tick();
        idle(3'b111); tick();
      end
      for (int i = 0; i < 3; i++) begin disp(2'(i), 32'hE0 + i, 0, 0, 0, 3'b000); tick(); end
      idle(3'b111);
      for (int i = 0; i < 3; i++) begin
        #1;
        tests++; if (issue_valid !== 1'b1 || issue_fu !== ord[p*3+i]) begin fails++; $display("FAIL rr_order%0d_%0d got v=%b fu=%0d exp %0d", p, i, issue_valid, issue_fu, ord[p*3+i]); end
        tick();
      end
      tests++; if (busy !== 3'b000) begin fails++; $display("FAIL rr_drain%0d got %b exp 000", p, busy); end
    end
  endtask

  task automatic test_flush();
    disp(0, 32'hF0, 0, 0, 1, 3'b000); tick();
    disp(1, 32'hF1, 0, 0, 0, 3'b000); tick();
    idle(3'b111); flush = 1; resolved = 1; #1;
    tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", issue_valid); end
    tick(); idle(3'b000);
    tests++; if (busy !== 3'b010) begin fails++; $display("FAIL flush_busy got %b exp 010", busy); end
    idle(3'b111); #1;
    tests++; if (issue_fu !== 2'd1 || issue_row !== 32'hF1) begin fails++; $display("FAIL flush_survivor got fu=%0d row=%h exp 1 f1", issue_fu, issue_row); end
    tick();
    disp(0, 32'hF2, 0, 0, 1, 3'b000); tick();
    idle(3'b000); resolved = 1; tick();
    idle(3'b000); flush = 1; tick();
    idle(3'b000);
    tests++; if (busy !== 3'b001) begin fails++; $display("FAIL resolved_keep got %b exp 001", busy); end
    idle(3'b111); tick();
  endtask

  task automatic test_dispatch_err();
    disp(0, 32'hAA, 0, 0, 0, 3'b000); tick();
    disp(0, 32'hBB, 0, 0, 0, 3'b000); tick();
    idle(3'b000);
    tests++; if (dispatch_err !== 1'b1 || busy !== 3'b001) begin fails++; $display("FAIL err_busy got err=%b busy=%b exp 1 001", dispatch_err, busy); end
    tick();
    tests++; if (dispatch_err !== 1'b0) begin fails++; $display("FAIL err_pulse got %b exp 0", dispatch_err); end
    disp(0, 32'hCC, 0, 0, 0, 3'b111); #1;
    tests++; if (issue_row !== 32'hAA) begin fails++; $display("FAIL err_unchanged got %h exp aa", issue_row); end
    tick(); idle(3'b111); #1;
    tests++; if (dispatch_err !== 1'b0 || issue_row !== 32'hCC) begin fails++; $display("FAIL refill_on_issue got err=%b row=%h exp 0 cc", dispatch_err, issue_row); end
    tick();
    disp(3, 32'hDD, 0, 0, 0, 3'b111); tick();
    idle(3'b111);
    tests++; if (dispatch_err !== 1'b1 || busy !== 3'b000) begin fails++; $display("FAIL err_fu3 got err=%b busy=%b exp 1 000", dispatch_err, busy); end
    disp(0, 32'hEE, 0, 0, 0, 3'b111); flush = 1; tick();
    idle(3'b111);
    tests++; if (dispatch_err !== 1'b0 || busy !== 3'b000) begin fails++; $display("FAIL flush_drop got err=%b busy=%b exp 0 000", dispatch_err, busy); end
  endtask

  // Model: per-row records plus a pointer; each edge applies issue, flush/resolve, wakeup, then write.
  task automatic test_random();
    logic [31:0] m_row [3];
    logic [1:0]  m_t1 [3], m_t2 [3];
    logic [2:0]  m_busy, m_spec;
    int          m_ptr, w;
    logic        m_err, e_valid, acc;
    logic [1:0]  e_fu;
    logic [31:0] e_row;
    idle(3'b111);
    nRST = 0; #1; nRST = 1;
    m_busy = 0; m_spec = 0; m_ptr = 0; m_err = 0;
    for (int i = 0; i < 3; i++) begin m_t1[i] = 0; m_t2[i] = 0; m_row[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 9) < 6); fu = 2'($urandom_range(0, 3)); fust_row = $urandom;
      t1 = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      t2 = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      spec = 1'($urandom); wb_valid = 1'($urandom); wb_tag = 2'($urandom_range(0, 3));
      fu_ready = 3'($urandom); flush = ($urandom_range(0, 11) == 0); resolved = ($urandom_range(0, 7) == 0);
      #1;
      w = -1;
      for (int k = 2; k >= 0; k--) begin
        int j;
        j = (m_ptr + k) % 3;
        if (m_busy[j] && m_t1[j] == 0 && m_t2[j] == 0 && fu_ready[j]) w = j;
      end
      e_valid = (w >= 0) && !flush;
      e_fu = e_valid ? 2'(w) : 2'd0;
      e_row = e_valid ? m_row[w] : 32'd0;
      tests++; if (issue_valid !== e_valid || issue_fu !== e_fu || issue_row !== e_row) begin fails++; $display("FAIL rand_issue c=%0d got v=%b fu=%0d row=%h exp v=%b fu=%0d row=%h", c, issue_valid, issue_fu, issue_row, e_valid, e_fu, e_row); end
      tests++; if (busy !== m_busy || dispatch_err !== m_err) begin fails++; $display("FAIL rand_state c=%0d got busy=%b err=%b exp busy=%b err=%b", c, busy, dispatch_err, m_busy, m_err); end
      acc = en && fu != 3 && (!m_busy[fu] || (e_valid && e_fu == fu)) && !flush;
      m_err = en && !acc && !flush;
      if (e_valid) begin m_busy[w] = 0; m_ptr = (w + 1) % 3; end
      if (flush) begin
        for (int i = 0; i < 3; i++) if (m_spec[i]) begin m_busy[i] = 0; m_t1[i] = 0; m_t2[i] = 0; end
        m_spec = 0;
      end else if (resolved) m_spec = 0;
      if (wb_valid && wb_tag != 0)
        for (int i = 0; i < 3; i++) begin
          if (m_t1[i] == wb_tag) m_t1[i] = 0;
          if (m_t2[i] == wb_tag) m_t2[i] = 0;
        end
      if (acc) begin
        m_busy[fu] = 1; m_row[fu] = fust_row; m_spec[fu] = spec;
        m_t1[fu] = (wb_valid && wb_tag != 0 && t1 == wb_tag) ? 2'd0 : t1;
        m_t2[fu] = (wb_valid && wb_tag != 0 && t2 == wb_tag) ? 2'd0 : t2;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wakeup();
    test_round_robin();
    test_flush();
    test_dispatch_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
